// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
//
// Multi-cycle shift unit. Performs LSL / LSR / ASR / ROR on a SIZE-bit
// operand, moving STEP bit positions per clock, and produces a registered
// result together with the N/Z/V/C flag nibble for the ALU flag mux.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start_i          request, accepted only while not busy
//   mode_i  [1:0]    00 LSL, 01 LSR, 10 ASR, 11 ROR (sampled with start_i)
//   in_a_i  [SIZE]   operand (sampled with start_i)
//   shift_i [M]      shift amount (sampled with start_i)
//   busy_o           high while shifting
//   done_o           one-cycle pulse, out_o/flags hold the new result
//   out_o   [SIZE]   registered result, held until the next result
//   flags_n_z_v_c_o  [3] N, [2] Z, [1] V, [0] C, registered with out_o
// ---------------------------------------------------------------------------
module shift_unit_seq #(
    parameter int SIZE = 16,
    parameter int M    = 4,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [SIZE-1:0] in_a_i,
    input  logic [M-1:0]    shift_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [SIZE-1:0] out_o,
    output logic [3:0]      flags_n_z_v_c_o
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // A STEP wider than the largest encodable amount can never be fully
    // used, so clamp it to what the remaining counter can express.
    localparam int unsigned     MAX_AMT = (1 << M) - 1;
    localparam logic [M-1:0]    STEP_M  = (STEP > MAX_AMT) ? M'(MAX_AMT) : M'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] work_q, work_d;
    logic [M-1:0]    rem_q, rem_d;
    logic [1:0]      mode_q, mode_d;
    logic            sign_q, sign_d;   // original in_a MSB: ASR fill and V reference
    logic            v_q, v_d;         // running "shifted-out bit differs from sign"
    logic            c_q, c_d;         // last bit shifted out so far
    logic [SIZE-1:0] out_q, out_d;
    logic [3:0]      flags_q, flags_d;

    logic            accept;
    logic [M-1:0]    step_k;
    logic [M-1:0]    rem_step;
    logic [SIZE-1:0] step_work;
    logic            step_c;
    logic            step_v;
    logic            fin_c;
    logic            fin_v;

    // Start is ignored while shifting; IDLE and DONE both accept.
    assign accept = start_i && (state_q != S_SHIFT);

    // ---------------------------------------------------------------------
    // One SHIFT cycle: move by k = min(STEP, remaining) single-bit steps.
    // ---------------------------------------------------------------------
    assign step_k   = (rem_q < STEP_M) ? rem_q : STEP_M;
    assign rem_step = rem_q - step_k;

    always_comb begin : step_logic
        step_work = work_q;
        step_c    = c_q;
        step_v    = v_q;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(step_k)) begin
                case (mode_q)
                    MODE_LSL: begin
                        step_c    = step_work[SIZE-1];
                        step_v    = step_v | (step_work[SIZE-1] ^ sign_q);
                        step_work = {step_work[SIZE-2:0], 1'b0};
                    end
                    MODE_LSR: begin
                        step_c    = step_work[0];
                        step_work = {1'b0, step_work[SIZE-1:1]};
                    end
                    MODE_ASR: begin
                        step_c    = step_work[0];
                        step_work = {sign_q, step_work[SIZE-1:1]};
                    end
                    default: begin
                        step_work = {step_work[0], step_work[SIZE-1:1]};
                    end
                endcase
            end
        end
    end

    // Final flags for an operation that finishes on this SHIFT edge.
    // ROR carry is the new MSB; V additionally catches a final sign change.
    assign fin_c = (mode_q == MODE_ROR) ? step_work[SIZE-1] : step_c;
    assign fin_v = (mode_q == MODE_LSL) ? (step_v | (step_work[SIZE-1] ^ sign_q)) : 1'b0;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = (shift_i != '0) ? S_SHIFT : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (rem_step == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath next values
    // ---------------------------------------------------------------------
    always_comb begin : datapath_next
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        v_d     = v_q;
        c_d     = c_q;
        out_d   = out_q;
        flags_d = flags_q;
        if (accept) begin
            work_d = in_a_i;
            rem_d  = shift_i;
            mode_d = mode_i;
            sign_d = in_a_i[SIZE-1];
            v_d    = 1'b0;
            c_d    = 1'b0;
            // A zero amount goes straight to DONE, so the result is the
            // operand itself with V and C cleared.
            if (shift_i == '0) begin
                out_d   = in_a_i;
                flags_d = {in_a_i[SIZE-1], ~|in_a_i, 2'b00};
            end
        end else if (state_q == S_SHIFT) begin
            work_d = step_work;
            rem_d  = rem_step;
            c_d    = step_c;
            v_d    = step_v;
            if (rem_step == '0) begin
                out_d   = step_work;
                flags_d = {step_work[SIZE-1], ~|step_work, fin_v, fin_c};
            end
        end
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSL;
            sign_q  <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            v_q     <= v_d;
            c_q     <= c_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: purely from registered state, no start->busy path.
    // ---------------------------------------------------------------------
    always_comb begin : outputs
        busy_o          = (state_q == S_SHIFT);
        done_o          = (state_q == S_DONE);
        out_o           = out_q;
        flags_n_z_v_c_o = flags_q;
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_seq
//
// Two instances share one clock and reset: u_s1 (SIZE=16, M=4, STEP=1) and
// u_s4 (SIZE=16, M=5, STEP=4, so amounts >= SIZE are reachable). Each
// operation is compared against an arithmetic reference model or against
// hand-derived constants; one line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_shift_unit_seq;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  mode   [2];
    logic [15:0] in_a   [2];
    logic [15:0] out_v  [2];
    logic [3:0]  flags  [2];
    logic [3:0]  sh0;
    logic [4:0]  sh1;

    logic [15:0] prev_out   [2];
    logic [3:0]  prev_flags [2];

    int total;
    int bad;

    shift_unit_seq #(.SIZE(16), .M(4), .STEP(1)) u_s1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start[0]),
        .mode_i          (mode[0]),
        .in_a_i          (in_a[0]),
        .shift_i         (sh0),
        .busy_o          (busy[0]),
        .done_o          (done[0]),
        .out_o           (out_v[0]),
        .flags_n_z_v_c_o (flags[0])
    );

    shift_unit_seq #(.SIZE(16), .M(5), .STEP(4)) u_s4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start[1]),
        .mode_i          (mode[1]),
        .in_a_i          (in_a[1]),
        .shift_i         (sh1),
        .busy_o          (busy[1]),
        .done_o          (done[1]),
        .out_o           (out_v[1]),
        .flags_n_z_v_c_o (flags[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: LSL as multiplication by 2^n (V = signed overflow), LSR/ASR
    // as wide right shifts keeping the bit just below the result as C, ROR
    // as a rotate by n mod 16.
    function automatic void model(input logic [1:0] md, input logic [15:0] a, input int n,
                                  output logic [15:0] res, output logic [3:0] fl);
        logic [63:0] w;
        longint      sa;
        longint      p;
        logic        c;
        logic        v;
        int          r;
        v = 1'b0;
        case (md)
            2'b00: begin
                w   = 64'(a) << n;
                res = w[15:0];
                c   = w[16];
                p   = longint'($signed(a)) * (longint'(1) << n);
                v   = (p > 32767) || (p < -32768);
            end
            2'b01: begin
                w   = {32'b0, a, 16'b0} >> n;
                res = w[31:16];
                c   = w[15];
            end
            2'b10: begin
                sa  = longint'($signed(a)) * 65536;
                sa  = sa >>> n;
                w   = sa;
                res = w[31:16];
                c   = w[15];
            end
            default: begin
                r   = n % 16;
                w   = {32'b0, a, a} >> r;
                res = w[15:0];
                c   = (n != 0) && res[15];
            end
        endcase
        fl = {res[15], (res == 16'h0000), v, c};
    endfunction

    function automatic int step_of(input int idx);
        return (idx == 0) ? 1 : 4;
    endfunction

    // Drive a request; called at a negedge, accepted at the next posedge.
    task automatic issue(input int idx, input logic [1:0] md, input logic [15:0] a, input int n);
        mode[idx] = md;
        in_a[idx] = a;
        if (idx == 0) sh0 = n[3:0];
        else          sh1 = n[4:0];
        start[idx] = 1'b1;
    endtask

    // Follows an issued request until done, checking latency, busy length,
    // output stability during SHIFT, and the final result. Returns at the
    // negedge where done is seen, with start already low.
    task automatic wait_result(input int idx, input string name, input int n,
                               input logic [15:0] exp_out, input logic [3:0] exp_fl,
                               input bit spam);
        int cyc;
        int busy_cnt;
        int exp_lat;
        bit got;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        exp_lat  = (n + step_of(idx) - 1) / step_of(idx) + 1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done[idx] === 1'b1) begin
                start[idx] = 1'b0;
                got = 1'b1;
                break;
            end
            if (busy[idx] === 1'b1) busy_cnt++;
            total++;
            if (out_v[idx] !== prev_out[idx] || flags[idx] !== prev_flags[idx]) begin
                bad++;
                $display("FAIL %s stable: out=%h flags=%b required out=%h flags=%b",
                         name, out_v[idx], flags[idx], prev_out[idx], prev_flags[idx]);
            end
            if (spam && busy[idx] === 1'b1) begin
                mode[idx] = 2'($urandom_range(0, 3));
                in_a[idx] = 16'($urandom);
                start[idx] = 1'b1;
            end else begin
                start[idx] = 1'b0;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done: no done within 60 cycles", name);
        end
        total++;
        if (cyc !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc, exp_lat);
        end
        total++;
        if (busy_cnt !== exp_lat - 1) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_lat - 1);
        end
        total++;
        if (out_v[idx] !== exp_out) begin
            bad++;
            $display("FAIL %s out: got %h required %h", name, out_v[idx], exp_out);
        end
        total++;
        if (flags[idx] !== exp_fl) begin
            bad++;
            $display("FAIL %s flags: got %b required %b", name, flags[idx], exp_fl);
        end
        prev_out[idx]   = exp_out;
        prev_flags[idx] = exp_fl;
        $display("op %s: inst=%0d n=%0d out=%h flags=%b lat=%0d", name, idx, n,
                 out_v[idx], flags[idx], cyc);
    endtask

    task automatic run_const(input int idx, input string name, input logic [1:0] md,
                             input logic [15:0] a, input int n,
                             input logic [15:0] exp_out, input logic [3:0] exp_fl);
        issue(idx, md, a, n);
        wait_result(idx, name, n, exp_out, exp_fl, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_v[i] !== 16'h0000 || flags[i] !== 4'b0000 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_values inst=%0d: out=%h flags=%b busy=%b done=%b required 0000/0000/0/0",
                         i, out_v[i], flags[i], busy[i], done[i]);
            end
            prev_out[i]   = 16'h0000;
            prev_flags[i] = 4'b0000;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (done !== 2'b00 || busy !== 2'b00) begin
                bad++;
                $display("FAIL idle_after_reset: done=%b busy=%b required 00/00", done, busy);
            end
        end
        $display("reset: out0=%h out1=%h", out_v[0], out_v[1]);
    endtask

    task automatic test_directed();
        run_const(0, "lsl_8001_1",   2'b00, 16'h8001, 1,  16'h0002, 4'b0011);
        run_const(0, "lsr_0001_1",   2'b01, 16'h0001, 1,  16'h0000, 4'b0101);
        run_const(0, "asr_8000_15",  2'b10, 16'h8000, 15, 16'hFFFF, 4'b1000);
        run_const(0, "ror_0001_4",   2'b11, 16'h0001, 4,  16'h1000, 4'b0000);
        run_const(1, "s4_lsl_00ff_7",  2'b00, 16'h00FF, 7,  16'h7F80, 4'b0000);
        run_const(1, "s4_lsl_1234_16", 2'b00, 16'h1234, 16, 16'h0000, 4'b0110);
        run_const(1, "s4_lsl_1235_16", 2'b00, 16'h1235, 16, 16'h0000, 4'b0111);
        run_const(1, "s4_asr_8000_20", 2'b10, 16'h8000, 20, 16'hFFFF, 4'b1001);
        run_const(1, "s4_lsr_ffff_17", 2'b01, 16'hFFFF, 17, 16'h0000, 4'b0100);
        run_const(1, "s4_ror_0001_20", 2'b11, 16'h0001, 20, 16'h1000, 4'b0000);
    endtask

    task automatic test_handshake();
        int extra;
        issue(0, 2'b00, 16'h00F0, 5);
        wait_result(0, "spam_lsl_00f0_5", 5, 16'h1E00, 4'b0000, 1'b1);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL spam_single_done: extra active cycles %0d required 0", extra);
        end
        // back-to-back: zero-shift op issued in the done cycle
        issue(0, 2'b11, 16'h00FF, 8);
        wait_result(0, "b2b_ror_00ff_8", 8, 16'hFF00, 4'b1001, 1'b0);
        issue(0, 2'b00, 16'h0000, 0);
        wait_result(0, "b2b_zero", 0, 16'h0000, 4'b0100, 1'b0);
        issue(1, 2'b01, 16'h8000, 9);
        wait_result(1, "s4_b2b_lsr_8000_9", 9, 16'h0040, 4'b0000, 1'b0);
        issue(1, 2'b00, 16'hC000, 1);
        wait_result(1, "s4_b2b_lsl_c000_1", 1, 16'h8000, 4'b1001, 1'b0);
        @(negedge clk);
        total++;
        if (done[1] !== 1'b0) begin
            bad++;
            $display("FAIL s4_done_pulse: done=%b required 0", done[1]);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        issue(0, 2'b10, 16'h8000, 15);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_v[0] !== 16'h0000 || flags[0] !== 4'b0000 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: out=%h flags=%b busy=%b done=%b required 0000/0000/0/0",
                     out_v[0], flags[0], busy[0], done[0]);
        end
        total++;
        if (out_v[1] !== 16'h0000 || flags[1] !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_s4: out=%h flags=%b required 0000/0000", out_v[1], flags[1]);
        end
        for (int i = 0; i < 2; i++) begin
            prev_out[i]   = 16'h0000;
            prev_flags[i] = 4'b0000;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 2'b00 || busy !== 2'b00) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL after_reset_quiet: active cycles %0d required 0", seen);
        end
        $display("async reset: out0=%h flags0=%b", out_v[0], flags[0]);
        run_const(0, "post_reset_lsl_0001_3", 2'b00, 16'h0001, 3, 16'h0008, 4'b0000);
    endtask

    task automatic test_random();
        logic [1:0]  md;
        logic [15:0] a;
        logic [15:0] er;
        logic [3:0]  ef;
        int          n;
        int          gap;
        for (int idx = 0; idx < 2; idx++) begin
            for (int k = 0; k < 30; k++) begin
                md = 2'($urandom_range(0, 3));
                a  = 16'($urandom);
                if (k % 7 == 0) a = 16'($urandom_range(0, 1)) << $urandom_range(0, 15);
                n  = (idx == 0) ? $urandom_range(0, 15) : $urandom_range(0, 31);
                model(md, a, n, er, ef);
                issue(idx, md, a, n);
                wait_result(idx, $sformatf("rnd%0d_m%0d_%h", idx, md, a), n, er, ef, 1'b0);
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    total++;
                    if (done[idx] !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd_gap_done: done=%b required 0", done[idx]);
                    end
                end
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 2'b00;
        mode[0] = 2'b00;
        mode[1] = 2'b00;
        in_a[0] = 16'h0000;
        in_a[1] = 16'h0000;
        sh0     = 4'd0;
        sh1     = 5'd0;
        test_reset();
        test_directed();
        test_handshake();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
